// File: rtl/symbol_error_counter_pkg.sv
// Shared definitions for the symbol error counter: FSM encoding and default sizing.
package symbol_error_counter_pkg;

  localparam int unsigned DefaultWindowLen = 4194303;
  localparam int unsigned DefaultCntW      = 22;

  typedef enum logic [1:0] {
    StIdle,
    StSync,
    StCount,
    StDone
  } state_e;

endpackage

// File: rtl/symbol_error_counter_sat_counter.sv
// Enabled, clearable up-counter that sticks at all-ones and flags any increment lost there.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] MaxVal = '1;

  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clear) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (enable) begin
      if (count_q == MaxVal) begin
        sat_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/symbol_error_counter.sv
// Windowed symbol error counter: arms on start, aligns to clear_accumulator, counts
// WINDOW_LEN qualified symbols, then publishes error/symbol totals for one DONE cycle.
module symbol_error_counter
  import symbol_error_counter_pkg::*;
#(
  parameter int unsigned WINDOW_LEN = DefaultWindowLen,
  parameter int unsigned CNT_W      = DefaultCntW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sym_clk_ena,
  input  logic             sym_correct,
  input  logic             sym_error,
  input  logic             clear_accumulator,
  input  logic             start,
  output logic             busy,
  output logic             result_valid,
  output logic [CNT_W-1:0] error_count,
  output logic [CNT_W-1:0] symbol_count,
  output logic             error_sat,
  output logic             verdict_fault
);

  // Count value seen just before the terminating symbol is added.
  localparam logic [CNT_W-1:0] LastSym = CNT_W'(WINDOW_LEN - 1);

  state_e state_q, state_d;

  logic             clear_run;
  logic             qualified;
  logic             last_sym;
  logic             in_done;
  logic [CNT_W-1:0] sym_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             err_sat_run;
  logic             sym_sat_run;
  logic             unused_sym_sat;
  logic             fault_q, fault_d;

  logic [CNT_W-1:0] err_lat_q, sym_lat_q;
  logic             sat_lat_q, fault_lat_q;

  assign clear_run = (state_q == StSync) && clear_accumulator;
  assign qualified = (state_q == StCount) && sym_clk_ena && (sym_correct || sym_error);
  assign last_sym  = qualified && (sym_cnt == LastSym);
  assign in_done   = (state_q == StDone);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StSync;
      StSync:  if (clear_accumulator) state_d = StCount;
      StCount: if (last_sym) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fault_d = fault_q;
    if (clear_run) begin
      fault_d = 1'b0;
    end else if (qualified && sym_correct && sym_error) begin
      fault_d = 1'b1;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sym_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear_run),
    .enable (qualified),
    .count  (sym_cnt),
    .sat    (sym_sat_run)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear_run),
    .enable (qualified && sym_error),
    .count  (err_cnt),
    .sat    (err_sat_run)
  );

  // The symbol counter cannot pass WINDOW_LEN, so its saturation flag never matters.
  assign unused_sym_sat = sym_sat_run;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      fault_q     <= 1'b0;
      err_lat_q   <= '0;
      sym_lat_q   <= '0;
      sat_lat_q   <= 1'b0;
      fault_lat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      if (in_done) begin
        err_lat_q   <= err_cnt;
        sym_lat_q   <= sym_cnt;
        sat_lat_q   <= err_sat_run;
        fault_lat_q <= fault_q;
      end
    end
  end

  // During DONE the running values are shown directly so results coincide with result_valid.
  assign busy          = (state_q == StSync) || (state_q == StCount);
  assign result_valid  = in_done;
  assign error_count   = in_done ? err_cnt     : err_lat_q;
  assign symbol_count  = in_done ? sym_cnt     : sym_lat_q;
  assign error_sat     = in_done ? err_sat_run : sat_lat_q;
  assign verdict_fault = in_done ? fault_q     : fault_lat_q;

endmodule
